// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned add/sub/mul/div unit with valid/ready handshakes on both sides.
// Optional result==0 flag is enabled by defining ARITH_ZERO_FLAG_EN.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           operation,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 error,
  output logic                 zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               error_q, error_d;
  logic               res_load;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_hi_nxt, div_lo_nxt;

  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_diff = {1'b0, A} - {1'b0, B};

  // Shift-add step: hi:lo holds partial product over multiplier bits still to consume.
  assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Restoring step: hi is the remainder, lo shifts dividend out and quotient in.
  assign div_shift  = {hi_q, lo_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, opnd_q};
  assign div_hi_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_lo_nxt = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    res_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = operation;
          case (operation)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              error_d  = 1'b0;
              res_load = 1'b1;
              state_d  = ST_DONE;
            end
            OP_SUB: begin
              result_d = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
              error_d  = 1'b0;
              res_load = 1'b1;
              state_d  = ST_DONE;
            end
            OP_MUL: begin
              opnd_d  = A;
              hi_d    = '0;
              lo_d    = B;
              cnt_d   = CW'(WIDTH);
              state_d = ST_BUSY;
            end
            default: begin
              if (B == '0) begin
                result_d = '0;
                error_d  = 1'b1;
                res_load = 1'b1;
                state_d  = ST_DONE;
              end else begin
                opnd_d  = B;
                hi_d    = '0;
                lo_d    = A;
                cnt_d   = CW'(WIDTH);
                state_d = ST_BUSY;
              end
            end
          endcase
        end
      end

      ST_BUSY: begin
        if (op_q == OP_MUL) begin
          hi_d = mul_hi_nxt;
          lo_d = mul_lo_nxt;
        end else begin
          hi_d = div_hi_nxt;
          lo_d = div_lo_nxt;
        end
        cnt_d = cnt_q - CW'(1);
        // Last iteration registers the result directly, giving WIDTH+1 cycles total latency.
        if (cnt_q == CW'(1)) begin
          result_d = {hi_d, lo_d};
          error_d  = 1'b0;
          res_load = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

`ifdef ARITH_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (res_load) begin
      zero_q <= (result_d == '0);
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign error     = error_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit at WIDTH=8: expected results are queued on
// accept and compared (value, flags, latency) when out_valid appears.
module tb_seq_arith_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     operation;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           error;
  logic           zero;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    logic           zf;
    int             lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] aa, bb;
    aa    = {{W{1'b0}}, a};
    bb    = {{W{1'b0}}, b};
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      2'b00: e.res = aa + bb;
      2'b01: e.res = aa - bb;
      2'b10: begin e.res = aa * bb; e.lat = W + 1; end
      default: begin
        if (b == '0) begin
          e.res = '0;
          e.err = 1'b1;
        end else begin
          e.res = {W'(a % b), W'(a / b)};
          e.lat = W + 1;
        end
      end
    endcase
`ifdef ARITH_ZERO_FLAG_EN
    e.zf = (e.res == '0);
`else
    e.zf = 1'b0;
`endif
    return e;
  endfunction

  // Drive one command at the negedge; it is accepted at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    check("out_valid_idle", out_valid, 0);
    operation = op;
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 2'($urandom);
    A         = W'($urandom);
    B         = W'($urandom);
  endtask

  // Count negedges from the accept edge until out_valid; returns the count.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 40);
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int   cyc;
    exp_t e;
    issue(op, a, b);
    wait_valid(cyc);
    e = sb_q.pop_front();
    check($sformatf("latency op%0d %0d,%0d", op, a, b), cyc, e.lat);
    check($sformatf("result op%0d %0d,%0d", op, a, b), result, e.res);
    check($sformatf("error op%0d %0d,%0d", op, a, b), error, e.err);
    check($sformatf("zero op%0d %0d,%0d", op, a, b), zero, e.zf);
    @(posedge clk);
    #1;
    check("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   seen;
    exp_t e;
    logic [2*W-1:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    operation = 2'b00;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_error", error, 0);
    check("rst_zero", zero, 0);

    run_cmd(2'b00, 8'd200, 8'd100);
    run_cmd(2'b01, 8'd6, 8'd3);
    run_cmd(2'b01, 8'd3, 8'd5);
    run_cmd(2'b10, 8'd15, 8'd13);
    run_cmd(2'b10, 8'd255, 8'd255);
    run_cmd(2'b10, 8'd0, 8'd77);
    run_cmd(2'b11, 8'd200, 8'd7);
    run_cmd(2'b11, 8'd5, 8'd9);
    run_cmd(2'b11, 8'd8, 8'd2);
    run_cmd(2'b11, 8'd8, 8'd0);
    run_cmd(2'b00, 8'd1, 8'd1);
    run_cmd(2'b11, 8'd255, 8'd1);
    run_cmd(2'b00, 8'd255, 8'd255);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i == 5) ? '0 : W'($urandom);
      run_cmd(2'($urandom_range(0, 3)), ra, rb);
    end

    // Backpressure: consumer stalls 5 cycles; a stray command must be ignored.
    out_ready = 1'b0;
    issue(2'b10, 8'd12, 8'd11);
    wait_valid(cyc);
    e = sb_q.pop_front();
    check("bp_latency", cyc, e.lat);
    held = e.res;
    for (int i = 0; i < 5; i++) begin
      check("bp_result", result, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      operation = 2'b00;
      A         = 8'd1;
      B         = 8'd2;
      in_valid  = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_result_final", result, held);
    @(posedge clk);
    #1;
    check("bp_out_valid_after_hs", out_valid, 0);
    check("bp_in_ready_after_hs", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_extra_result", seen, 0);

    // Reset during the 4th BUSY cycle of a divide discards it.
    @(negedge clk);
    operation = 2'b11;
    A         = 8'd200;
    B         = 8'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_result", result, 0);
    check("mid_rst_error", error, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_stale", seen, 0);
    run_cmd(2'b00, 8'd40, 8'd2);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational arithmetic unit: add, sub, mul, div on WIDTH-bit unsigned operands.
- Add/sub finish in one cycle. Mul uses shift-add and div uses restoring division, one bit per cycle.
- Valid/ready handshakes on input and output; result and flags are registered and held until consumed.
- Sits between a command source and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); result width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  unit can accept a command.
- operation  input  2  00 add, 01 sub, 10 mul, 11 div.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- out_valid  output  1  result/error valid.
- out_ready  input  1  consumer accepts result.
- result  output  2*WIDTH  registered result.
- error  output  1  divide-by-zero flag, qualified by out_valid.
- zero  output  1  result==0 flag (see Optional Feature).

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; in_ready=1; out_valid=0; result=0; error=0; zero=0; counter and internal registers cleared.
  - Reset mid-operation (BUSY or DONE) discards the command and any pending result; no out_valid is produced for it.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - Accept on in_valid && in_ready: latch operation, A and B.
  - Add/sub: compute and register the result and flags, then go to DONE.
  - Div with B==0: result=0, error=1, go to DONE.
  - Mul, or div with B!=0: load the working registers, counter=WIDTH, go to BUSY.
- BUSY:
  - in_ready=0.
  - One iteration per cycle; the counter decrements each cycle.
  - When the counter reaches 0, register result and flags and go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - result, error and zero are held stable while out_ready=0 (backpressure has no limit).
  - On out_valid && out_ready, go to IDLE next cycle with out_valid=0.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - add, sub, div-by-zero: 1 cycle.
  - mul, div: WIDTH+1 cycles.
- Throughput: one command in flight. The next accept is possible in the cycle after the output handshake.
- Arithmetic (all operands unsigned):
  - add: result = zero-extended (WIDTH+1)-bit A+B.
  - sub: result = A-B as a 2*WIDTH two's-complement value (sign-extended from bit WIDTH). A<B gives a negative value.
  - mul: result = A*B, full 2*WIDTH product, exact.
  - div: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
- error=1 only for div with B==0; otherwise 0.
- Inputs are ignored when in_ready=0. Operands are sampled only at the accept edge, so later changes on A, B or operation have no effect.
- rst takes priority over every other event in the same cycle.

Optional Feature:
- Macro: ARITH_ZERO_FLAG_EN.
- Defined: zero is registered with the result and equals 1 iff result==0 at completion. Divide-by-zero reports zero=1 with error=1.
- Undefined: zero is tied to 0; no comparator logic is synthesised. All other behaviour is identical.

Test Plan (WIDTH=8):
- Add 200+100, out_ready=1 -> out_valid exactly 1 cycle after accept, result=0x012C, error=0. Sub 6-3 -> 0x0003. Sub 3-5 -> 0xFFFE.
- Mul 15*13 -> result=0x00C3, out_valid exactly 9 cycles after accept. Mul 255*255 -> 0xFE01. Mul 0*77 -> 0x0000; zero=1 only with ARITH_ZERO_FLAG_EN.
- Div 200/7 -> result=0x041C (quotient 28, remainder 4) after 9 cycles. Div 5/9 -> 0x0500. Div 8/2 -> 0x0004.
- Div 8/0 -> out_valid 1 cycle after accept, error=1, result=0x0000. The next command, add 1+1, gives error=0 and result=0x0002.
- Backpressure: mul completes with out_ready=0 for 5 cycles -> result stable, in_ready=0, a new in_valid is ignored. Raising out_ready gives one handshake, then IDLE.
- Assert rst for 1 cycle at the 4th BUSY cycle of a div -> next cycle out_valid=0, in_ready=1, result=0, and no stale result ever appears. A fresh add then completes normally.
